// File: rtl/pcs_tx_ordered_set_if.sv
// Transmit bus between the GMII-style MAC, the ordered-set controller and
// the 8b/10b encoder. The master side is the MAC/encoder pair; the slave side
// is the ordered-set controller.
interface pcs_tx_ordered_set_if;
  logic       tx_en;
  logic       tx_er;
  logic [7:0] txd;
  logic       tx_disparity_pos;
  logic [7:0] tx_octet;
  logic       tx_is_k;
  logic       tx_even;
  logic       tx_busy;

  modport master (
    output tx_en, tx_er, txd, tx_disparity_pos,
    input  tx_octet, tx_is_k, tx_even, tx_busy
  );

  modport slave (
    input  tx_en, tx_er, txd, tx_disparity_pos,
    output tx_octet, tx_is_k, tx_even, tx_busy
  );
endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set controller.
// Sequences /I/ idle pairs, /S/ + frame data, and /T/R/[R/] end-of-packet
// towards the 8b/10b encoder, and owns code-group parity so that every comma
// (K28.5) and /S/ lands on an even slot.
// Optional feature macro: PCS_TX_ERR_PROP_EN -- when defined, tx_er during a
// frame emits /V/ (K30.7) in place of the data octet.
module pcs_tx_ordered_set (
  input  logic                        sync_clk,
  input  logic                        mr_main_reset,
  pcs_tx_ordered_set_if.slave         bus
);

  localparam logic [7:0] K28_5 = 8'hBC;  // comma, first half of /I/
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/
  localparam logic [7:0] D5_6  = 8'hC5;  // /I1/ second half (flips disparity)
  localparam logic [7:0] D16_2 = 8'h50;  // /I2/ second half (keeps disparity)

  typedef enum logic [2:0] {
    ST_IDLE_K = 3'd0,
    ST_IDLE_D = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_END_T  = 3'd4,
    ST_END_R1 = 3'd5,
    ST_END_R2 = 3'd6
  } state_e;

  state_e     state_q,    state_d;
  logic [7:0] tx_octet_q, tx_octet_d;
  logic       tx_is_k_q,  tx_is_k_d;
  logic       tx_even_q,  tx_even_d;
  logic       tx_busy_q,  tx_busy_d;

  // A slot belongs to a frame from /S/ through the last /R/.
  function automatic logic is_frame_state(input state_e st);
    logic busy;
    case (st)
      ST_START, ST_DATA, ST_END_T, ST_END_R1, ST_END_R2: busy = 1'b1;
      default:                                            busy = 1'b0;
    endcase
    return busy;
  endfunction

`ifndef PCS_TX_ERR_PROP_EN
  // tx_er has no consumer in this build; keep it visibly terminated.
  logic unused_tx_er_s;
  assign unused_tx_er_s = bus.tx_er;
`endif

  // Next-slot decision: state transition first, then the octet that slot carries.
  always_comb begin
    state_d    = state_q;
    tx_octet_d = K28_5;
    tx_is_k_d  = 1'b1;
    tx_even_d  = ~tx_even_q;

    case (state_q)
      ST_IDLE_K: state_d = ST_IDLE_D;
      ST_IDLE_D: begin
        if (bus.tx_en) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE_K;
        end
      end
      ST_START, ST_DATA: begin
        if (bus.tx_en) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_END_T;
        end
      end
      ST_END_T:  state_d = ST_END_R1;
      // A second /R/ is only needed when the first one sat on an even slot,
      // so that the following comma is realigned to even.
      ST_END_R1: begin
        if (tx_even_q) begin
          state_d = ST_END_R2;
        end else begin
          state_d = ST_IDLE_K;
        end
      end
      ST_END_R2: state_d = ST_IDLE_K;
      default:   state_d = ST_IDLE_K;
    endcase

    case (state_d)
      ST_IDLE_K: begin
        tx_octet_d = K28_5;
        tx_is_k_d  = 1'b1;
      end
      ST_IDLE_D: begin
        // /I1/ pulls a positive running disparity back negative.
        if (bus.tx_disparity_pos) begin
          tx_octet_d = D5_6;
        end else begin
          tx_octet_d = D16_2;
        end
        tx_is_k_d = 1'b0;
      end
      ST_START: begin
        tx_octet_d = K27_7;
        tx_is_k_d  = 1'b1;
      end
      ST_DATA: begin
`ifdef PCS_TX_ERR_PROP_EN
        if (bus.tx_er) begin
          tx_octet_d = K30_7;
          tx_is_k_d  = 1'b1;
        end else begin
          tx_octet_d = bus.txd;
          tx_is_k_d  = 1'b0;
        end
`else
        tx_octet_d = bus.txd;
        tx_is_k_d  = 1'b0;
`endif
      end
      ST_END_T: begin
        tx_octet_d = K29_7;
        tx_is_k_d  = 1'b1;
      end
      ST_END_R1, ST_END_R2: begin
        tx_octet_d = K23_7;
        tx_is_k_d  = 1'b1;
      end
      default: begin
        tx_octet_d = K28_5;
        tx_is_k_d  = 1'b1;
      end
    endcase

    tx_busy_d = is_frame_state(state_d);
  end

  // State and output registers; reset truncates any frame and parks on an even comma.
  always_ff @(posedge sync_clk) begin
    if (mr_main_reset) begin
      state_q    <= ST_IDLE_K;
      tx_octet_q <= K28_5;
      tx_is_k_q  <= 1'b1;
      tx_even_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_octet_q <= tx_octet_d;
      tx_is_k_q  <= tx_is_k_d;
      tx_even_q  <= tx_even_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign bus.tx_octet = tx_octet_q;
  assign bus.tx_is_k  = tx_is_k_q;
  assign bus.tx_even  = tx_even_q;
  assign bus.tx_busy  = tx_busy_q;

endmodule

// File: doc/pcs_tx_ordered_set.md
# pcs_tx_ordered_set

Transmit-side ordered-set controller for the 1000BASE-X PCS. Sits between the GMII-style MAC interface and the 8b/10b encoder, and sequences the octet stream fed to the encoder:
- /I/ idle pairs;
- /S/ start, frame data and /V/ error propagation;
- /T/R/ or /T/R/R/ end-of-packet.

It owns code-group parity (`tx_even`) so that every K28.5 lands on an even position. The receive synchronization block depends on that alignment.

## Interface
Parameters: none.
- `sync_clk` in 1: code-group clock, rising edge.
- `mr_main_reset` in 1: reset, synchronous, active-high.
- `tx_en` in 1: MAC transmit enable.
- `tx_er` in 1: MAC transmit error.
- `txd` in 8: MAC transmit octet.
- `tx_disparity_pos` in 1: encoder running disparity, 1 = positive.
- `tx_octet` out 8: octet to the encoder.
- `tx_is_k` out 1: 1 = `tx_octet` is a K code, 0 = D code.
- `tx_even` out 1: 1 = current code-group is at an even position.
- `tx_busy` out 1: 1 while in START, DATA, END_T, END_R1 or END_R2.

## Operation
- All outputs are registered, and each edge loads the next slot. `tx_even` toggles on every edge and never holds.
- Octet encodings:
  - K28.5 = 0xBC; /S/ K27.7 = 0xFB; /T/ K29.7 = 0xFD; /R/ K23.7 = 0xF7; /V/ K30.7 = 0xFE.
  - D5.6 = 0xC5; D16.2 = 0x50.
- States, with the octet each one emits:
  - IDLE_K: 0xBC, K, always even.
  - IDLE_D: odd slot, D. Emits 0xC5 (/I1/) if `tx_disparity_pos` = 1 at the loading edge, otherwise 0x50 (/I2/).
  - START: 0xFB, K, always even.
  - DATA: `txd` as D. Emits 0xFE as K instead when `tx_er` = 1 (see Configuration).
  - END_T: 0xFD, K.
  - END_R1, END_R2: 0xF7, K.
- Transitions, evaluated at each edge:
  - IDLE_K → IDLE_D unconditionally. `tx_en` is ignored here.
  - IDLE_D → START if `tx_en` = 1, else → IDLE_K.
  - START → DATA if `tx_en` = 1, else → END_T.
  - DATA → DATA while `tx_en` = 1, else → END_T.
  - END_T → END_R1.
  - END_R1 → END_R2 if END_R1 occupied an even slot, else → IDLE_K.
  - END_R2 → IDLE_K.
- Preamble shortening: the `txd` octet sampled at the IDLE_D→START edge is replaced by /S/. An octet sampled while the controller is leaving IDLE_K is dropped. The first DATA octet is therefore the 2nd or 3rd octet of the MAC frame. This shortening is required behaviour.
- Back-to-back frames: `tx_en` asserted during END_T, END_R1 or END_R2 is not acted on until the next IDLE_D decision. At least one full /I/ pair always separates frames.

## Timing
- Reset, sampled at an edge, loads the following values; they hold for as long as reset stays high:
  - state = IDLE_K;
  - `tx_octet` = 0xBC, `tx_is_k` = 1, `tx_even` = 1, `tx_busy` = 0.
- First edge after reset release: IDLE_D with `tx_even` = 0.
- Data latency: `txd` sampled at edge n appears on `tx_octet` immediately after edge n, i.e. one register stage.
- From the first `tx_en` = 1 sample to /S/ on the output: 1 or 2 edges, depending on parity.
- Reset asserted mid-frame: the frame is truncated immediately. No /T/ is sent, and the next state is IDLE_K.
- `tx_en` = 0 for a single cycle inside a frame ends the frame with /T/R/. It is never bridged.
- Invariants:
  - 0xBC and 0xFB are only ever output with `tx_even` = 1.
  - The slot after END_T is never 0xBC.

## Configuration
- Macro `PCS_TX_ERR_PROP_EN`.
  - Defined: in DATA, `tx_er` = 1 with `tx_en` = 1 emits /V/ (0xFE, K) in place of `txd`.
  - Undefined: `tx_er` is ignored and `txd` is always passed as D.
- In both builds, `tx_er` with `tx_en` = 0 has no effect. Carrier extension is not supported.

## Test plan
- Reset then idle: after `mr_main_reset` is released, `tx_octet` alternates 0xBC(K, even) / 0x50(D, odd) with `tx_disparity_pos` = 0. With `tx_disparity_pos` = 1 the D octet becomes 0xC5.
- Even start: raise `tx_en` so that it is sampled at an IDLE_D→START edge, with `txd` = 55,55,D5,A1,B2. Required output: FB(K, even), 55, D5, A1, B2, then FD, F7, with R2 present iff R1 was even, then 0xBC on an even slot.
- Odd start: raise `tx_en` one cycle later than in the even-start case. Required: one extra idle D, then /S/ on even, and one further preamble octet dropped.
- Error propagation: with `PCS_TX_ERR_PROP_EN` defined, pulse `tx_er` for one cycle mid-frame → a single FE(K) in place of that octet. With the macro undefined → the original `txd` octet appears.
- Back-to-back: drop `tx_en` for one cycle between two frames → /T/R/[R/] then at least one /I/ pair before the second /S/. `tx_busy` falls for that idle period.
- Reset mid-frame: assert `mr_main_reset` during DATA → next output is 0xBC, K, `tx_even` = 1, `tx_busy` = 0, with no /T/.
